// File: rtl/sdram_port_arbiter_pkg.sv
// Shared encodings and widths for the two-port SDRAM command arbiter.
package sdram_port_arbiter_pkg;

  localparam int SDRAM_WORD_W = 32;
  localparam int STRB_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester (I/D) and controller command-port signals; the arbiter uses the slave view,
// the surrounding requesters and controller the master view.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25
);
  import sdram_port_arbiter_pkg::*;

  logic                    i_req;
  logic [ADDR_W-1:0]       i_addr;
  logic                    i_ready;
  logic [SDRAM_WORD_W-1:0] i_rdata;

  logic                    d_req;
  logic                    d_we;
  logic [ADDR_W-1:0]       d_addr;
  logic [SDRAM_WORD_W-1:0] d_wdata;
  logic [STRB_W-1:0]       d_wstrb;
  logic                    d_ready;
  logic [SDRAM_WORD_W-1:0] d_rdata;

  logic                    m_valid;
  logic                    m_we;
  logic [ADDR_W-1:0]       m_addr;
  logic [SDRAM_WORD_W-1:0] m_wdata;
  logic [STRB_W-1:0]       m_wstrb;
  logic                    m_accept;
  logic                    m_done;
  logic [SDRAM_WORD_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
           m_accept, m_done, m_rdata,
    output i_ready, i_rdata, d_ready, d_rdata,
           m_valid, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
           m_accept, m_done, m_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata,
           m_valid, m_we, m_addr, m_wdata, m_wstrb
  );

endinterface

// File: rtl/sdram_arb_pick.sv
// Winner selection between I and D with a starvation counter that forces I
// through after MAX_SKIP consecutive D grants.
module sdram_arb_pick
  import sdram_port_arbiter_pkg::*;
#(
  parameter int MAX_SKIP = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   grant,
  output owner_t winner
);

  localparam int              SKIP_W   = $clog2(MAX_SKIP + 1);
  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);

  logic [SKIP_W-1:0] skip_q;

  assign winner = (!d_req || (i_req && skip_q == SKIP_MAX)) ? OWN_I : OWN_D;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_q <= '0;
    end else if (!i_req || (grant && winner == OWN_I)) begin
      skip_q <= '0;
    end else if (grant && skip_q != SKIP_MAX) begin
      skip_q <= skip_q + SKIP_W'(1);
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between instruction fetch (I) and
// data load/store (D), one whole transaction at a time.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int MAX_SKIP = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_done,
  sdram_port_arbiter_if.slave  bus,
  output logic                 busy
);

  state_t state_q, state_d;
  owner_t owner_q, winner;
  logic   load_cmd, accept_cmd, take_done;

  logic                    cmd_we;
  logic [ADDR_W-1:0]       cmd_addr;
  logic [SDRAM_WORD_W-1:0] cmd_wdata;
  logic [STRB_W-1:0]       cmd_wstrb;

  sdram_arb_pick #(.MAX_SKIP(MAX_SKIP)) u_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
    .grant  (load_cmd),
    .winner (winner)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    load_cmd   = 1'b0;
    accept_cmd = 1'b0;
    take_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_done && (bus.i_req || bus.d_req)) begin
          load_cmd = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // m_done is deliberately ignored until the command has been accepted.
        if (bus.m_accept) begin
          accept_cmd = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.m_done) begin
          take_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction fetches are always full-word reads with no byte enables.
  always_comb begin
    cmd_we    = 1'b0;
    cmd_addr  = bus.i_addr;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    if (winner == OWN_D) begin
      cmd_we    = bus.d_we;
      cmd_addr  = bus.d_addr;
      cmd_wdata = bus.d_wdata;
      cmd_wstrb = bus.d_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_I;
      bus.m_valid <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.m_wstrb <= '0;
    end else if (load_cmd) begin
      owner_q     <= winner;
      bus.m_valid <= 1'b1;
      bus.m_we    <= cmd_we;
      bus.m_addr  <= cmd_addr;
      bus.m_wdata <= cmd_wdata;
      bus.m_wstrb <= cmd_wstrb;
    end else if (accept_cmd) begin
      bus.m_valid <= 1'b0;
    end
  end

  // NOTE: the rdata holding registers are reset as well, since every output must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.i_ready <= 1'b0;
      bus.d_ready <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      bus.i_ready <= take_done && (owner_q == OWN_I);
      bus.d_ready <= take_done && (owner_q == OWN_D);
      if (take_done && owner_q == OWN_I) bus.i_rdata <= bus.m_rdata;
      if (take_done && owner_q == OWN_D) bus.d_rdata <= bus.m_rdata;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: init gating, stalled write, mixed
// arbitration, starvation limit, mid-transaction reset and early m_done.
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic init_done = 1'b0;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .MAX_SKIP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .bus       (bus),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first ISSUE cycle; returns in the ready cycle.
  task automatic serve(input int acc_dly, input logic [31:0] rdata);
    bus.m_accept = 1'b0;
    for (int k = 0; k < acc_dly; k++) step();
    bus.m_accept = 1'b1;
    step();
    bus.m_accept = 1'b0;
    bus.m_done   = 1'b1;
    bus.m_rdata  = rdata;
    step();
    bus.m_done   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen;
    logic       stable;
    int         pulses;
    int         n;
    logic [9:0] exp_seq;

    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.m_accept = 0; bus.m_done = 0; bus.m_rdata = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #10;
    check("rst_m_valid", 64'(bus.m_valid), 64'h0);
    check("rst_i_ready", 64'(bus.i_ready), 64'h0);
    check("rst_d_ready", 64'(bus.d_ready), 64'h0);
    check("rst_busy",    64'(busy),        64'h0);
    check("rst_m_addr",  64'(bus.m_addr),  64'h0);
    #1 rst_n = 1'b1;

    // Requests held while init_done=0, then released
    bus.i_req = 1'b1; bus.i_addr = 25'h40;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bus.m_valid || bus.i_ready || busy) seen = 1'b1;
    end
    check("init_hold", 64'(seen), 64'h0);
    init_done = 1'b1;
    step();
    check("init_m_valid", 64'(bus.m_valid), 64'h1);
    check("init_m_addr",  64'(bus.m_addr),  64'h40);
    check("init_m_we",    64'(bus.m_we),    64'h0);
    check("init_m_wstrb", 64'(bus.m_wstrb), 64'h0);
    serve(0, 32'h1111_2222);
    check("init_i_ready", 64'(bus.i_ready), 64'h1);
    check("init_i_rdata", 64'(bus.i_rdata), 64'h1111_2222);
    bus.i_req = 1'b0;
    step();
    check("init_i_ready_drop", 64'(bus.i_ready), 64'h0);

    // Single D write, stalled accept, late done, requester fields change after grant
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 25'h100;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'b0011;
    step();
    check("wr_m_we",    64'(bus.m_we),    64'h1);
    check("wr_m_addr",  64'(bus.m_addr),  64'h100);
    check("wr_m_wdata", 64'(bus.m_wdata), 64'hDEAD_BEEF);
    check("wr_m_wstrb", 64'(bus.m_wstrb), 64'h3);
    bus.d_addr = 25'h0ABC0; bus.d_wdata = 32'h0; bus.d_wstrb = 4'hF;
    stable = 1'b1;
    seen   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (!(bus.m_valid && bus.m_we && bus.m_addr == 25'h100 &&
            bus.m_wdata == 32'hDEAD_BEEF && bus.m_wstrb == 4'b0011)) stable = 1'b0;
      if (bus.i_ready) seen = 1'b1;
    end
    check("wr_stall_stable", 64'(stable), 64'h1);
    bus.m_accept = 1'b1;
    step();
    bus.m_accept = 1'b0;
    check("wr_accept_clears_valid", 64'(bus.m_valid), 64'h0);
    check("wr_busy_wait", 64'(busy), 64'h1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.d_ready) pulses++;
      if (bus.i_ready) seen = 1'b1;
    end
    bus.m_done = 1'b1; bus.m_rdata = 32'h0;
    step();
    bus.m_done = 1'b0;
    bus.d_req  = 1'b0;
    if (bus.d_ready) pulses++;
    if (bus.i_ready) seen = 1'b1;
    step();
    if (bus.d_ready) pulses++;
    if (bus.i_ready) seen = 1'b1;
    check("wr_d_ready_pulses", 64'(pulses), 64'h1);
    check("wr_i_ready_quiet",  64'(seen),   64'h0);

    // Both request at once: D read first, then I
    bus.d_we = 1'b0; bus.d_addr = 25'h10; bus.d_wstrb = 4'h0;
    bus.i_addr = 25'h20;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    step();
    check("mix_first_addr", 64'(bus.m_addr), 64'h10);
    check("mix_first_we",   64'(bus.m_we),   64'h0);
    serve(0, 32'hAAAA_5555);
    check("mix_d_ready",   64'(bus.d_ready), 64'h1);
    check("mix_d_rdata",   64'(bus.d_rdata), 64'hAAAA_5555);
    check("mix_i_hold",    64'(bus.i_rdata), 64'h1111_2222);
    bus.d_req = 1'b0;
    step();
    check("mix_second_addr", 64'(bus.m_addr), 64'h20);
    serve(0, 32'h1234_5678);
    check("mix_i_ready", 64'(bus.i_ready), 64'h1);
    check("mix_i_rdata", 64'(bus.i_rdata), 64'h1234_5678);
    check("mix_d_hold",  64'(bus.d_rdata), 64'hAAAA_5555);
    check("mix_d_quiet", 64'(bus.d_ready), 64'h0);
    bus.i_req = 1'b0;
    step();

    // Starvation limit: D,D,D,D,I,D,D,D,D,I (bit i = 1 means D)
    exp_seq = 10'b01111_01111;
    bus.i_addr = 25'h200; bus.d_addr = 25'h300; bus.d_we = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (!bus.m_valid && n < 5) begin
        step();
        n++;
      end
      check($sformatf("skip_valid_%0d", i), 64'(bus.m_valid), 64'h1);
      check($sformatf("skip_seq_%0d", i), 64'(bus.m_addr == 25'h300), 64'(exp_seq[i]));
      serve(0, 32'h1000 + 32'(i));
    end
    check("skip_i_rdata", 64'(bus.i_rdata), 64'h1009);
    check("skip_d_rdata", 64'(bus.d_rdata), 64'h1008);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    step();

    // Reset during WAIT, stale m_done around release
    bus.d_req = 1'b1; bus.d_addr = 25'h40;
    step();
    bus.m_accept = 1'b1;
    step();
    bus.m_accept = 1'b0;
    bus.d_req = 1'b0;
    check("rstw_busy_before", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_busy",    64'(busy),        64'h0);
    check("rstw_m_valid", 64'(bus.m_valid), 64'h0);
    check("rstw_m_addr",  64'(bus.m_addr),  64'h0);
    check("rstw_i_rdata", 64'(bus.i_rdata), 64'h0);
    check("rstw_d_rdata", 64'(bus.d_rdata), 64'h0);
    bus.m_done = 1'b1; bus.m_rdata = 32'hBAD;
    #2 rst_n = 1'b1;
    step();
    check("rstw_no_d_ready", 64'(bus.d_ready), 64'h0);
    check("rstw_no_i_ready", 64'(bus.i_ready), 64'h0);
    check("rstw_idle",       64'(busy),        64'h0);
    bus.m_done = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 25'h80;
    step();
    check("rstw_regrant_valid", 64'(bus.m_valid), 64'h1);
    check("rstw_regrant_addr",  64'(bus.m_addr),  64'h80);
    serve(0, 32'h0BAD_F00D);
    check("rstw_i_ready", 64'(bus.i_ready), 64'h1);
    check("rstw_i_rdata", 64'(bus.i_rdata), 64'h0BAD_F00D);
    bus.i_req = 1'b0;
    step();

    // m_done before accept is ignored
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 25'h44;
    step();
    bus.m_done = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
    step();
    bus.m_done = 1'b0;
    check("early_no_ready", 64'(bus.d_ready), 64'h0);
    check("early_valid",    64'(bus.m_valid), 64'h1);
    bus.m_accept = 1'b1;
    step();
    bus.m_accept = 1'b0;
    step();
    check("early_wait_quiet", 64'(bus.d_ready), 64'h0);
    bus.m_done = 1'b1; bus.m_rdata = 32'h55AA_55AA;
    step();
    bus.m_done = 1'b0;
    bus.d_req  = 1'b0;
    check("early_d_ready", 64'(bus.d_ready), 64'h1);
    check("early_d_rdata", 64'(bus.d_rdata), 64'h55AA_55AA);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.d_ready || bus.i_ready) pulses++;
    end
    check("early_single_pulse", 64'(pulses), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
